// File: rtl/sliscp_perm.sv
// ---------------------------------------------------------------------------
// sliscp_perm -- iterative SLiSCP-light permutation engine.
//
// Runs STEPS steps of ROUNDS_PER_STEP Simeck rounds on the two odd subblocks
// (s1 through box S1, s3 through box S3), then applies the step-end mixing
// layer. The step constants come from an external combinational ROM that is
// addressed by const_idx.
//
// Build option:
//   SLISCP_PERM_UNROLL2_EN  - when defined, two Simeck rounds per box are done
//                             per cycle (ROUNDS_PER_STEP must then be even).
//                             Results are bit-identical to the default build.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      permutation request, accepted only while ready=1
//   sin        input state {s0,s1,s2,s3}, s0 in the MSBs, sampled on accept
//   rc0, rc1   round-constant bits for S1 / S3 of the current step (LSB first)
//   sc0, sc1   step constants for s0 / s2 of the current step
//   const_idx  step index presented to the constant ROM
//   ready      high while idle
//   done       one-cycle pulse when sout becomes valid
//   sout       result state, held until the next accept
// ---------------------------------------------------------------------------
module sliscp_perm #(
    parameter int WIDTH           = 64,
    parameter int STEPS           = 18,
    parameter int ROUNDS_PER_STEP = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [4*WIDTH-1:0]                          sin,
    input  logic [7:0]                                  rc0,
    input  logic [7:0]                                  rc1,
    input  logic [7:0]                                  sc0,
    input  logic [7:0]                                  sc1,
    output logic [((STEPS > 1) ? $clog2(STEPS) : 1)-1:0] const_idx,
    output logic                                        ready,
    output logic                                        done,
    output logic [4*WIDTH-1:0]                          sout
);

    localparam int H  = WIDTH / 2;
    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int RW = (ROUNDS_PER_STEP > 1) ? $clog2(ROUNDS_PER_STEP) : 1;

`ifdef SLISCP_PERM_UNROLL2_EN
    localparam int RSTEP = 2;
    if (ROUNDS_PER_STEP % 2 != 0) begin : g_odd_rounds
        $error("sliscp_perm: ROUNDS_PER_STEP must be even when two rounds are done per cycle");
    end
`else
    localparam int RSTEP = 1;
`endif

    if ((WIDTH % 2 != 0) || (WIDTH < 16) || (STEPS < 1) ||
        (ROUNDS_PER_STEP < 1) || (ROUNDS_PER_STEP > 8)) begin : g_bad_params
        $error("sliscp_perm: illegal WIDTH/STEPS/ROUNDS_PER_STEP combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One Simeck round on a WIDTH-bit word: the upper half goes through f,
    // the halves swap, and the round-constant bit lands in the LSB of an
    // otherwise all-ones mask.
    function automatic logic [WIDTH-1:0] simeck_round(input logic [WIDTH-1:0] x,
                                                      input logic             rc_bit);
        logic [H-1:0] xl;
        logic [H-1:0] xr;
        logic [H-1:0] f;
        xl = x[WIDTH-1:H];
        xr = x[H-1:0];
        f  = (xl & {xl[H-6:0], xl[H-1:H-5]}) ^ {xl[H-2:0], xl[H-1]};
        return {xr ^ f ^ {{(H-1){1'b1}}, rc_bit}, xl};
    endfunction

    state_t               fsm_q, fsm_d;
    logic [4*WIDTH-1:0]   state_q, state_d;
    logic [4*WIDTH-1:0]   sout_q, sout_d;
    logic [RW-1:0]        round_ctr_q, round_ctr_d;
    logic [CW-1:0]        step_ctr_q, step_ctr_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     s0, s1, s2, s3;
    logic [WIDTH-1:0]     box1, box3;
    logic [WIDTH-1:0]     sc0_ext, sc1_ext;
    logic [2:0]           rc_idx0;
`ifdef SLISCP_PERM_UNROLL2_EN
    logic [2:0]           rc_idx1;
`endif
    logic [4*WIDTH-1:0]   round_state;
    logic [4*WIDTH-1:0]   mixed_state;
    logic                 last_round;
    logic                 last_step;

    // Datapath: the Simeck boxes on s1/s3 for the current round(s), plus the
    // mixing layer that is folded into the final round of every step.
    always_comb begin
        s0 = state_q[4*WIDTH-1:3*WIDTH];
        s1 = state_q[3*WIDTH-1:2*WIDTH];
        s2 = state_q[2*WIDTH-1:WIDTH];
        s3 = state_q[WIDTH-1:0];

        rc_idx0 = 3'(round_ctr_q);
        box1    = simeck_round(s1, rc0[rc_idx0]);
        box3    = simeck_round(s3, rc1[rc_idx0]);
`ifdef SLISCP_PERM_UNROLL2_EN
        rc_idx1 = rc_idx0 + 3'd1;
        box1    = simeck_round(box1, rc0[rc_idx1]);
        box3    = simeck_round(box3, rc1[rc_idx1]);
`endif

        sc0_ext = {{(WIDTH-8){1'b1}}, sc0};
        sc1_ext = {{(WIDTH-8){1'b1}}, sc1};

        round_state = {s0, box1, s2, box3};
        mixed_state = {box1, box3 ^ s2 ^ sc1_ext, box3, s0 ^ sc0_ext ^ box1};

        last_round = (round_ctr_q == RW'(ROUNDS_PER_STEP - RSTEP));
        last_step  = (step_ctr_q == CW'(STEPS - 1));
    end

    // Control: next-state and next-output values for the FSM, counters and
    // registered outputs. sout only moves when the last step completes.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        sout_d      = sout_q;
        round_ctr_d = round_ctr_q;
        step_ctr_d  = step_ctr_q;
        ready_d     = ready_q;
        done_d      = 1'b0;

        case (fsm_q)
            IDLE: begin
                ready_d = 1'b1;
                if (start) begin
                    state_d     = sin;
                    round_ctr_d = '0;
                    step_ctr_d  = '0;
                    ready_d     = 1'b0;
                    fsm_d       = RUN;
                end
            end
            RUN: begin
                ready_d = 1'b0;
                if (last_round) begin
                    state_d     = mixed_state;
                    round_ctr_d = '0;
                    if (last_step) begin
                        // Step counter returns to 0 so const_idx never
                        // addresses past the ROM.
                        sout_d     = mixed_state;
                        step_ctr_d = '0;
                        done_d     = 1'b1;
                        fsm_d      = DONE;
                    end else begin
                        step_ctr_d = step_ctr_q + CW'(1);
                    end
                end else begin
                    state_d     = round_state;
                    round_ctr_d = round_ctr_q + RW'(RSTEP);
                end
            end
            DONE: begin
                ready_d = 1'b1;
                fsm_d   = IDLE;
            end
            default: begin
                ready_d = 1'b1;
                fsm_d   = IDLE;
            end
        endcase
    end

    // All state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            sout_q      <= '0;
            round_ctr_q <= '0;
            step_ctr_q  <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            sout_q      <= sout_d;
            round_ctr_q <= round_ctr_d;
            step_ctr_q  <= step_ctr_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign const_idx = step_ctr_q;
    assign ready     = ready_q;
    assign done      = done_q;
    assign sout      = sout_q;

endmodule

// File: doc/sliscp_perm.md
Name: sliscp_perm

Overview:
- Iterative, parametrised SLiSCP-light permutation engine. Generalises the single step datapath into a complete multi-step permutation.
- Runs STEPS steps of ROUNDS_PER_STEP Simeck rounds each, plus the step-end mixing layer.
- Has its own control FSM, round and step counters, a start/ready/done handshake, and a step-indexed constant fetch.
- Sits between the sponge/AEAD controller and an external constant ROM.

Parameters:
WIDTH, 64, subblock width in bits (48 for the 192-bit state, 64 for the 256-bit state); must be even and at least 16
STEPS, 18, number of steps per permutation call; at least 1
ROUNDS_PER_STEP, 8, Simeck rounds per step (6 for WIDTH=48); range 1..8

Ports:
clk  in  1  clock; all flops rising-edge
rst  in  1  asynchronous, active-high reset
start  in  1  request a permutation; accepted only when ready=1
sin  in  4*WIDTH  input state {s0,s1,s2,s3}, s0 in the MSBs; sampled on accept
rc0  in  8  round-constant bits for the S1 box, current step
rc1  in  8  round-constant bits for the S3 box, current step
sc0  in  8  step constant for s0
sc1  in  8  step constant for s2
const_idx  out  $clog2(STEPS) (min 1)  step index presented to the constant ROM; constants must be valid in the same cycle (combinational ROM)
ready  out  1  high in IDLE
done  out  1  one-cycle pulse when sout becomes valid
sout  out  4*WIDTH  result state; held until the next accept

Behaviour:
- Reset values: state register 0, sout 0, ready 1, done 0, const_idx 0. FSM goes to IDLE, counters go to 0.
- FSM states:
  - IDLE: ready=1. If start=1, load the state from sin, clear the counters and go to RUN.
  - RUN: ready=0. One Simeck round per box per cycle.
  - DONE: done=1 for one cycle, ready=0, then go to IDLE.
- start while not ready is ignored; there is no queueing.
- Simeck box on a WIDTH-bit word:
  - Split into xl (upper half) and xr (lower half), each H=WIDTH/2 bits.
  - f(x) = (x & rotl(x,5)) ^ rotl(x,1), H-bit rotates.
  - Round r: xl' = xr ^ f(xl) ^ {ones(H-1), rc[r]}; xr' = xl.
  - S1 uses rc0 and S3 uses rc1; rc bit r is used in round r, LSB first.
- Step end, on the cycle where round_ctr == ROUNDS_PER_STEP-1: the round result is combined combinationally with the mixing layer and registered.
  - scX_ext = {ones(WIDTH-8), scX}
  - s0' = S1 result
  - s1' = S3 result ^ s2 ^ sc1_ext
  - s2' = S3 result
  - s3' = s0 ^ sc0_ext ^ S1 result
- At step end, round_ctr wraps to 0 and step_ctr increments.
- const_idx = step_ctr throughout RUN.
- Last round of the last step: the result goes to the state register and to sout, and the FSM goes to DONE.
- Latency: accept at edge N; done is high in the cycle after edge N + STEPS*ROUNDS_PER_STEP. Throughput is one permutation per STEPS*ROUNDS_PER_STEP + 2 cycles.
- Edge cases:
  - start in the DONE cycle is ignored.
  - start in the IDLE cycle immediately after DONE is accepted.
  - STEPS=1 and ROUNDS_PER_STEP=1 is legal: one RUN cycle.
  - Reset mid-RUN aborts immediately and restores all reset values.
- sout changes only at completion or reset, never during RUN.

Optional Feature:
- Macro SLISCP_PERM_UNROLL2_EN.
- When defined:
  - Two Simeck rounds per box per cycle, using rc bits r and r+1.
  - round_ctr advances by 2.
  - ROUNDS_PER_STEP must be even; otherwise elaboration fails via a generate-time error.
  - Latency becomes STEPS*ROUNDS_PER_STEP/2.
- When undefined: one round per cycle as above.
- Results are bit-identical in both builds.

Test Plan:
- Reset and idle: assert rst asynchronously mid-cycle -> sout=0, ready=1, done=0 immediately, without waiting for a clock edge.
- Minimal case: WIDTH=48, STEPS=1, ROUNDS=1, sin=0, rc0=0x00, rc1=0x01, sc0=sc1=0x00 -> sout = {48'hFFFFFE000000, 48'h000000FFFF00, 48'hFFFFFF000000, 48'h000001FFFF00}; done 1 cycle after accept.
- Full-size timing and constants: WIDTH=64, STEPS=18, ROUNDS=8, random sin -> done exactly 144 cycles after accept; const_idx walks 0..17, each value held 8 cycles; sout matches the C model.
- Ignored start: pulse start at RUN cycle 50 with different sin -> result unchanged.
- Back-to-back: start held high -> second accept occurs in the IDLE cycle after DONE; both results match the model.
- Mid-run reset, then unroll build: rst at RUN cycle 70 -> reset values, then a fresh start produces a correct result. UNROLL2 build with the full-size vector -> identical sout; done 72 cycles after accept.
